byte_parity_check: RTL and testbench
====================================

# byte_parity_check

Receive-side checker for the byte parity generator. It latches two data bytes and the per-bit parity word that was sent with them, where expected parity is `byte_parity[i] = byte_a[i] ^ byte_b[i]`. It then verifies the word serially, one bit per clock, and reports a pass/fail flag, a mismatch mask, a mismatch count and the index of the first failing bit. It sits at the far end of the parity link, opposite the generator, and uses the same start/done handshake.

## Interface
- `DATA_WIDTH`, default 8: width of the data bytes and of the parity word; must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a check; sampled only in IDLE.
- `byte_a` in DATA_WIDTH: data operand A; latched when `start` is accepted.
- `byte_b` in DATA_WIDTH: data operand B; latched when `start` is accepted.
- `byte_parity` in DATA_WIDTH: received parity word; latched when `start` is accepted.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle.
- `done` out 1: single-cycle pulse; result outputs are valid from this cycle.
- `parity_err` out 1: high when any bit mismatched.
- `err_mask` out DATA_WIDTH: bit i set when `byte_parity[i] != byte_a[i]^byte_b[i]`.
- `err_count` out $clog2(DATA_WIDTH+1): number of set bits in `err_mask`.
- `first_err_idx` out $clog2(DATA_WIDTH): lowest mismatching index; 0 when there are no errors.

## Operation
- FSM states: IDLE, CHECK, DONE.
- IDLE
  - When `start`=1: latch the three input words, clear `err_mask`, `err_count`, `first_err_idx`, `parity_err` and the internal first-error-found flag, set `bit_idx`=0, go to CHECK.
  - When `start`=0: stay in IDLE. Result outputs hold their previous values.
- CHECK
  - Each cycle, compare latched bit `bit_idx`.
  - On a mismatch: set `err_mask[bit_idx]`, increment `err_count`, set `parity_err`.
  - On the first mismatch only: load `first_err_idx` = `bit_idx`.
  - If `bit_idx` = DATA_WIDTH-1, go to DONE; otherwise increment `bit_idx`.
- DONE: `done`=1 for exactly this one cycle, then go to IDLE.
- `start` is ignored in CHECK and DONE. No queuing: a request that is dropped must be re-presented in IDLE.
- Input words may change freely after acceptance; only the latched copies are checked.
- `err_count` saturates naturally because its maximum value is DATA_WIDTH. No wrap is possible.
- Reset, in any state including mid-CHECK: next state IDLE; `busy`=0, `done`=0, `parity_err`=0, `err_mask`=0, `err_count`=0, `first_err_idx`=0, `bit_idx`=0. The partial check is discarded.
- `reset` and `start` asserted in the same cycle: reset wins and the request is dropped.

## Timing
- `start` accepted at edge T.
- CHECK occupies cycles T+1 … T+DATA_WIDTH, handling bits 0 … DATA_WIDTH-1.
- `done` is high in cycle T+DATA_WIDTH+1. For DATA_WIDTH=8 that is 9 cycles after acceptance.
- `busy` is high in cycles T+1 … T+DATA_WIDTH+1.
- Back-to-back rate: the earliest next acceptance is T+DATA_WIDTH+2, i.e. one request per DATA_WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Intermediate values of `err_*` during CHECK are not guaranteed; they are specified only from `done` until the next acceptance.

## Structure
- Shared package `byte_parity_pkg`:
  - state enum `bp_chk_state_t` (IDLE, CHECK, DONE)
  - default `DATA_WIDTH` constant (8)
  - width helper constants for the count and index fields
- One sub-module, `bit_parity_check`: combinational one-bit compare.
  - Inputs: `bit_a`, `bit_b`, `bit_parity`.
  - Output: `bit_err` = `bit_parity ^ bit_a ^ bit_b`.
  - A single instance, fed from the latched words through a `bit_idx` mux.
- The top level holds the FSM, bit counter, latches and accumulators.

## Test plan
- a=8'hA5, b=8'h3C, parity=8'h99, start at T → `done` at T+9; `parity_err`=0, `err_mask`=8'h00, `err_count`=0, `first_err_idx`=0.
- Same a/b, parity=8'h98 → `err_mask`=8'h01, `err_count`=1, `first_err_idx`=0, `parity_err`=1.
- Same a/b, parity=8'h19 → `err_mask`=8'h80, `err_count`=1, `first_err_idx`=7. Parity=8'h66 → `err_mask`=8'hFF, `err_count`=8, `first_err_idx`=0.
- Same a/b, parity=8'h91 → `err_mask`=8'h08, `err_count`=1, `first_err_idx`=3.
- `start` held high continuously while inputs are changed after T → acceptances only at T, T+10, T+20; each result reflects the inputs present at its own acceptance edge.
- `reset` at T+4 during CHECK → next cycle IDLE, all outputs 0, no `done` pulse. `start` together with `reset` → request ignored, `busy` stays 0.

Source files
------------

// File: rtl/byte_parity_pkg.sv
// byte_parity_pkg: shared types and width helpers for the byte parity checker.
//   bp_chk_state_t     : checker FSM states
//   DEFAULT_DATA_WIDTH : default data/parity word width
//   cnt_width/idx_width: widths of the mismatch count and bit index fields
package byte_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } bp_chk_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Count must hold 0..width inclusive; index must address 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned width);
    return $clog2(width);
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_DATA_WIDTH);
  localparam int unsigned DEFAULT_IDX_W = idx_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/byte_parity_check_if.sv
// byte_parity_check_if: start/done handshake plus data and result bus of the
// parity checker.
//   master: drives start, byte_a, byte_b, byte_parity; observes results
//   slave : the checker; observes request, drives busy, done and results
interface byte_parity_check_if
  import byte_parity_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
  localparam int unsigned IDX_W = idx_width(DATA_WIDTH);

  logic                  start;
  logic [DATA_WIDTH-1:0] byte_a;
  logic [DATA_WIDTH-1:0] byte_b;
  logic [DATA_WIDTH-1:0] byte_parity;
  logic                  busy;
  logic                  done;
  logic                  parity_err;
  logic [DATA_WIDTH-1:0] err_mask;
  logic [CNT_W-1:0]      err_count;
  logic [IDX_W-1:0]      first_err_idx;

  modport master (
    output start, byte_a, byte_b, byte_parity,
    input  busy, done, parity_err, err_mask, err_count, first_err_idx
  );

  modport slave (
    input  start, byte_a, byte_b, byte_parity,
    output busy, done, parity_err, err_mask, err_count, first_err_idx
  );

endinterface

// File: rtl/bit_parity_check.sv
// bit_parity_check: combinational single-bit parity compare.
//   bit_a, bit_b : data bits
//   bit_parity   : received parity bit
//   bit_err      : 1 when bit_parity != bit_a ^ bit_b
module bit_parity_check (
  input  logic bit_a,
  input  logic bit_b,
  input  logic bit_parity,
  output logic bit_err
);

  assign bit_err = bit_parity ^ bit_a ^ bit_b;

endmodule

// File: rtl/byte_parity_check.sv
// byte_parity_check: receive-side parity checker. Latches two data words and
// their parity word on an accepted start, checks one bit per clock, then
// pulses done with pass/fail, mismatch mask, mismatch count and first index.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of byte_parity_check_if (request in, results out)
module byte_parity_check
  import byte_parity_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  byte_parity_check_if.slave   bus
);

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
  localparam int unsigned IDX_W = idx_width(DATA_WIDTH);

  bp_chk_state_t         state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] lat_a_q, lat_a_d;
  logic [DATA_WIDTH-1:0] lat_b_q, lat_b_d;
  logic [DATA_WIDTH-1:0] lat_p_q, lat_p_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  found_q, found_d;
  logic                  parity_err_q, parity_err_d;
  logic [DATA_WIDTH-1:0] err_mask_q, err_mask_d;
  logic [CNT_W-1:0]      err_count_q, err_count_d;
  logic [IDX_W-1:0]      first_idx_q, first_idx_d;
  logic                  bit_err;

  // Single comparator fed from the latched words through the bit_idx mux.
  bit_parity_check u_bit_chk (
    .bit_a      (lat_a_q[bit_idx_q]),
    .bit_b      (lat_b_q[bit_idx_q]),
    .bit_parity (lat_p_q[bit_idx_q]),
    .bit_err    (bit_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d      = state_q;
    lat_a_d      = lat_a_q;
    lat_b_d      = lat_b_q;
    lat_p_d      = lat_p_q;
    bit_idx_d    = bit_idx_q;
    found_d      = found_q;
    parity_err_d = parity_err_q;
    err_mask_d   = err_mask_q;
    err_count_d  = err_count_q;
    first_idx_d  = first_idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          lat_a_d      = bus.byte_a;
          lat_b_d      = bus.byte_b;
          lat_p_d      = bus.byte_parity;
          bit_idx_d    = '0;
          found_d      = 1'b0;
          parity_err_d = 1'b0;
          err_mask_d   = '0;
          err_count_d  = '0;
          first_idx_d  = '0;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (bit_err) begin
          err_mask_d[bit_idx_q] = 1'b1;
          // At most DATA_WIDTH increments per check, so the count cannot wrap.
          err_count_d  = err_count_q + CNT_W'(1);
          parity_err_d = 1'b1;
          if (!found_q) begin
            found_d     = 1'b1;
            first_idx_d = bit_idx_q;
          end
        end
        if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered views of the upcoming state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_a_q      <= '0;
      lat_b_q      <= '0;
      lat_p_q      <= '0;
      bit_idx_q    <= '0;
      found_q      <= 1'b0;
      parity_err_q <= 1'b0;
      err_mask_q   <= '0;
      err_count_q  <= '0;
      first_idx_q  <= '0;
    end else begin
      lat_a_q      <= lat_a_d;
      lat_b_q      <= lat_b_d;
      lat_p_q      <= lat_p_d;
      bit_idx_q    <= bit_idx_d;
      found_q      <= found_d;
      parity_err_q <= parity_err_d;
      err_mask_q   <= err_mask_d;
      err_count_q  <= err_count_d;
      first_idx_q  <= first_idx_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.parity_err    = parity_err_q;
  assign bus.err_mask      = err_mask_q;
  assign bus.err_count     = err_count_q;
  assign bus.first_err_idx = first_idx_q;

endmodule

// File: tb/tb_byte_parity_check.sv
// tb_byte_parity_check: directed self-checking bench for byte_parity_check
// with DATA_WIDTH=8 and hand-computed expected results.
module tb_byte_parity_check;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  byte_parity_check_if #(.DATA_WIDTH(W)) bus ();

  byte_parity_check #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
    bus.byte_a      = a;
    bus.byte_b      = b;
    bus.byte_parity = p;
  endtask

  // Waits after the acceptance edge until done; returns edges waited.
  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    if (bus.done !== 1'b1) begin
      check({tag, "_done_timeout"}, 32'(bus.done), 32'd1);
    end
  endtask

  task automatic check_results(input string tag, input logic perr, input logic [7:0] mask,
                               input logic [3:0] cnt, input logic [2:0] first);
    check({tag, "_parity_err"}, 32'(bus.parity_err), 32'(perr));
    check({tag, "_err_mask"}, 32'(bus.err_mask), 32'(mask));
    check({tag, "_err_count"}, 32'(bus.err_count), 32'(cnt));
    check({tag, "_first_idx"}, 32'(bus.first_err_idx), 32'(first));
  endtask

  // Full single request: accept, wait for done (8 edges later), check results,
  // then confirm done drops after one cycle.
  task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, input logic perr, input logic [7:0] mask,
                         input logic [3:0] cnt, input logic [2:0] first);
    int edges;
    set_inputs(a, b, p);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_inputs(~a, b, ~p);
    check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    wait_done(tag, edges);
    check({tag, "_latency"}, 32'(edges), 32'(W));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    check_results(tag, perr, mask, cnt, first);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check_results({tag, "_hold"}, perr, mask, cnt, first);
  endtask

  initial begin
    int edges;
    int done_seen;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    set_inputs(8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_results("rst", 1'b0, 8'h00, 4'd0, 3'd0);
    reset = 1'b0;
    tick();

    // A5 ^ 3C = 99
    run_vec("clean", 8'hA5, 8'h3C, 8'h99, 1'b0, 8'h00, 4'd0, 3'd0);
    run_vec("bit0",  8'hA5, 8'h3C, 8'h98, 1'b1, 8'h01, 4'd1, 3'd0);
    run_vec("bit7",  8'hA5, 8'h3C, 8'h19, 1'b1, 8'h80, 4'd1, 3'd7);
    run_vec("all",   8'hA5, 8'h3C, 8'h66, 1'b1, 8'hFF, 4'd8, 3'd0);
    run_vec("bit3",  8'hA5, 8'h3C, 8'h91, 1'b1, 8'h08, 4'd1, 3'd3);
    run_vec("b2b5",  8'hA5, 8'h3C, 8'hBD, 1'b1, 8'h24, 4'd2, 3'd2);

    // start held high: acceptances 10 edges apart, each using its own inputs.
    set_inputs(8'hA5, 8'h3C, 8'h98);
    bus.start = 1'b1;
    tick();
    set_inputs(8'hFF, 8'h00, 8'h0F);
    wait_done("hold1", edges);
    check("hold1_latency", 32'(edges), 32'(W));
    check_results("hold1", 1'b1, 8'h01, 4'd1, 3'd0);
    tick();
    check("hold1_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    check("hold2_accept_busy", 32'(bus.busy), 32'd1);
    set_inputs(8'h12, 8'h34, 8'h26);
    wait_done("hold2", edges);
    check("hold2_latency", 32'(edges), 32'(W));
    check_results("hold2", 1'b1, 8'hF0, 4'd4, 3'd4);
    tick();
    check("hold2_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    check("hold3_accept_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    set_inputs(8'h00, 8'h00, 8'hFF);
    wait_done("hold3", edges);
    check("hold3_latency", 32'(edges), 32'(W));
    check_results("hold3", 1'b0, 8'h00, 4'd0, 3'd0);
    tick();

    // Reset in mid-check: partial results discarded, no done pulse.
    set_inputs(8'hA5, 8'h3C, 8'h66);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_partial_err", 32'(bus.parity_err), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check_results("mid_rst", 1'b0, 8'h00, 4'd0, 3'd0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);

    // start together with reset is dropped.
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    check("rst_start_busy_after", 32'(bus.busy), 32'd0);
    check("rst_start_done_after", 32'(bus.done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
